pipedelayreg_multi: RTL and testbench
=====================================

Name: pipedelayreg_multi

Overview:
- Parametrised successor of the one-cycle pipeline delay register.
- Holds a WIDTH-bit pipeline value and stalls the issuing stage for DELAY consecutive cycles when a result with a non-zero destination register enters the stage.
- Queues a squash that arrives while the stage is not enabled, and applies it at the next enabled cycle.
- Sits between pipeline stages wherever a multi-cycle functional-unit result must be held back, for example a multi-cycle shifter or multiplier writeback.

Parameters:
- WIDTH, 32: data width of d and q.
- DELAY, 1: number of stall cycles per qualifying request. Legal range 0..15; 0 gives a plain pipereg with squash queueing.
- CNTW, 4: counter width. Must satisfy 2^CNTW > DELAY.

Ports:
- clk  in  1  clock; every flop is clocked on the rising edge.
- reset  in  1  synchronous reset, active-high.
- d  in  WIDTH  data in.
- en  in  1  stage enable / request.
- squashn  in  1  active-low squash.
- dst  in  5  destination register number; 0 means no writeback.
- q  out  WIDTH  registered data.
- stalled  out  1  combinational stall request to the pipeline.
- squash_pend  out  1  registered flag: a squash is queued.

Behaviour:
- Reset (reset=1 at a clock edge): q=0, squash_pend=0, state=IDLE, cnt=0. stalled is forced to 0 while reset=1.
- Qualifying request: req = en & (|dst).
- State machine: IDLE, STALL, RELEASE.
  - IDLE: stalled = req, in the same cycle (zero-latency assertion).
    - If req and DELAY>=2: go to STALL with cnt = DELAY-2.
    - If req and DELAY==1: go to RELEASE.
    - Otherwise stay in IDLE.
  - STALL: stalled = req.
    - If req=0 (request withdrawn): go to IDLE and clear cnt.
    - Else if cnt==0: go to RELEASE.
    - Else decrement cnt.
  - RELEASE: stalled = 0. Next state is IDLE unconditionally, so a request still held after release starts a fresh stall only from the following cycle.
  - DELAY==0: state stays IDLE and stalled is constant 0.
- Net effect: a request held continuously sees stalled=1 for exactly DELAY cycles (cycles 0..DELAY-1), then stalled=0 in cycle DELAY.
- Data register, priority order at each edge:
  1. reset: q <= 0, squash_pend <= 0.
  2. en & (~squashn | squash_pend): q <= 0, squash_pend <= 0.
  3. ~en & ~squashn: squash_pend <= 1; q holds.
  4. en: q <= d.
  5. Otherwise q holds.
- q is loaded on every enabled cycle, including stalled cycles. The final value is the d present on the release cycle.
- A squash does not affect the stall state machine. The upstream stage must drop en to abort a stall.
- Simultaneous events:
  - squashn=0 and a pending squash in the same enabled cycle: a single clear.
  - reset during STALL: IDLE on the next cycle, stalled=0 during the reset cycle.
- No arithmetic beyond the CNTW-bit down-counter. cnt never wraps because STALL exits at 0.

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_STALL=2'd1, ST_RELEASE=2'd2;
  - DST_W=5.
- One sub-module is natural: stall_counter (the state machine plus down-counter; inputs req, DELAY; output stalled).
- The data/squash register stays in the top module.

Test Plan:
- DELAY=3; en=1, dst=5'd7 held for 5 cycles from cycle 0 → stalled=1,1,1,0 in cycles 0..3; state IDLE in cycle 4 with stalled=1 again (new request).
- DELAY=3; en=1, dst=0 → stalled stays 0; q follows d one cycle later (d=32'hA5A5_0001 → q=32'hA5A5_0001).
- DELAY=4; request in cycle 0, en dropped in cycle 2 → stalled=0 in cycle 2; IDLE in cycle 3; re-request in cycle 3 gives stalled=1 for 4 more cycles.
- en=0, squashn=0 in cycle 0 → squash_pend=1 in cycle 1, q holds 32'h1234; en=1, d=32'hFFFF in cycle 2 → q=0 and squash_pend=0 in cycle 3; next en loads 32'hFFFF.
- reset=1 mid-STALL (DELAY=5, cycle 2) → stalled=0 that cycle; then q=0, squash_pend=0, IDLE; first request after reset stalls the full 5 cycles.
- DELAY=0 → stalled is never asserted over 100 random en/dst/squashn cycles; q matches a reference pipereg model extended with squash queueing.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the multi-cycle pipeline delay register.
package pipe_pkg;

  localparam int DST_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/stall_counter.sv
// Stall sequencer: holds a qualifying request stalled for DELAY cycles.
// state      | meaning
// ST_IDLE    | no stall in progress; a request stalls immediately
// ST_STALL   | stall in progress; cnt_q counts remaining stall cycles minus one
// ST_RELEASE | stall done; stalled drops for one cycle before returning to idle
module stall_counter
  import pipe_pkg::*;
#(
  parameter int DELAY = 1,
  parameter int CNTW  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic stalled
);

  localparam int LOAD = (DELAY >= 2) ? DELAY - 2 : 0;

  state_t            state_q;
  logic [CNTW-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req && DELAY >= 2) begin
            state_q <= ST_STALL;
            cnt_q   <= CNTW'(LOAD);
          end else if (req && DELAY == 1) begin
            state_q <= ST_RELEASE;
          end
        end
        ST_STALL: begin
          // withdrawal aborts the stall; counter exits at zero so it never wraps
          if (!req) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    stalled = 1'b0;
    if (!reset && DELAY != 0) begin
      case (state_q)
        ST_IDLE, ST_STALL: stalled = req;
        default:           stalled = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pipedelayreg_multi.sv
// Pipeline data register with a DELAY-cycle stall on writeback requests
// and queueing of squashes that arrive while the stage is disabled.
module pipedelayreg_multi
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DELAY = 1,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             squashn,
  input  logic [DST_W-1:0] dst,
  output logic [WIDTH-1:0] q,
  output logic             stalled,
  output logic             squash_pend
);

  logic             req;
  logic [WIDTH-1:0] q_d, q_q;
  logic             pend_d, pend_q;

  assign req = en & (|dst);

  stall_counter #(
    .DELAY (DELAY),
    .CNTW  (CNTW)
  ) u_stall (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .stalled (stalled)
  );

  always_comb begin
    q_d    = q_q;
    pend_d = pend_q;
    if (en && (!squashn || pend_q)) begin
      q_d    = '0;
      pend_d = 1'b0;
    end else if (!en && !squashn) begin
      pend_d = 1'b1;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      pend_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      pend_q <= pend_d;
    end
  end

  assign q           = q_q;
  assign squash_pend = pend_q;

endmodule

// File: tb/tb_pipedelayreg_multi.sv
// Directed/random bench for pipedelayreg_multi at DELAY = 0, 3, 4, 5.
module tb_pipedelayreg_multi;

  logic        clk = 1'b0;
  logic        reset, en, squashn;
  logic [4:0]  dst;
  logic [31:0] d;

  logic        st_w   [4];
  logic [31:0] q_w    [4];
  logic        pend_w [4];

  int sel;
  int n_assert = 0;
  int n_fail   = 0;

  int          m_delay, m_pos;
  logic [31:0] m_q;
  logic        m_pend;
  logic        st_obs;

  logic        exp_st [$];
  logic [31:0] exp_q  [$];
  logic        exp_p  [$];

  always #5 clk = ~clk;

  pipedelayreg_multi #(.WIDTH(32), .DELAY(0), .CNTW(4)) u_d0 (
    .clk(clk), .reset(reset), .d(d), .en(en), .squashn(squashn), .dst(dst),
    .q(q_w[0]), .stalled(st_w[0]), .squash_pend(pend_w[0]));
  pipedelayreg_multi #(.WIDTH(32), .DELAY(3), .CNTW(4)) u_d3 (
    .clk(clk), .reset(reset), .d(d), .en(en), .squashn(squashn), .dst(dst),
    .q(q_w[1]), .stalled(st_w[1]), .squash_pend(pend_w[1]));
  pipedelayreg_multi #(.WIDTH(32), .DELAY(4), .CNTW(4)) u_d4 (
    .clk(clk), .reset(reset), .d(d), .en(en), .squashn(squashn), .dst(dst),
    .q(q_w[2]), .stalled(st_w[2]), .squash_pend(pend_w[2]));
  pipedelayreg_multi #(.WIDTH(32), .DELAY(5), .CNTW(4)) u_d5 (
    .clk(clk), .reset(reset), .d(d), .en(en), .squashn(squashn), .dst(dst),
    .q(q_w[3]), .stalled(st_w[3]), .squash_pend(pend_w[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic select(input int s, input int dly);
    sel     = s;
    m_delay = dly;
  endtask

  // one clock cycle: drive, predict, check stalled mid-cycle, check q/pend after edge
  task automatic cyc(input logic r, input logic e, input logic sn,
                     input logic [4:0] ds, input logic [31:0] dd);
    logic        rq;
    logic [31:0] nq;
    logic        np;
    @(negedge clk);
    reset = r; en = e; squashn = sn; dst = ds; d = dd;
    rq = e & (|ds);
    exp_st.push_back(!r && rq && (m_delay > 0) && (m_pos < m_delay));
    nq = m_q;
    np = m_pend;
    if (r) begin
      nq = '0; np = 1'b0;
    end else if (e && (!sn || m_pend)) begin
      nq = '0; np = 1'b0;
    end else if (!e && !sn) begin
      np = 1'b1;
    end else if (e) begin
      nq = dd;
    end
    exp_q.push_back(nq);
    exp_p.push_back(np);
    if (r || !rq || m_pos >= m_delay) m_pos = 0;
    else m_pos = m_pos + 1;
    m_q    = nq;
    m_pend = np;
    #1;
    st_obs = st_w[sel];
    check("stalled", {31'b0, st_obs}, {31'b0, exp_st.pop_front()});
    @(posedge clk);
    #1;
    check("q", q_w[sel], exp_q.pop_front());
    check("squash_pend", {31'b0, pend_w[sel]}, {31'b0, exp_p.pop_front()});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    int         nst;
    reset = 1'b1; en = 1'b0; squashn = 1'b1; dst = '0; d = '0;
    m_pos = 0; m_q = '0; m_pend = 1'b0;
    select(1, 3);

    // DELAY=3, request held for 5 cycles
    cyc(1, 0, 1, 5'd0, 32'h0);
    check("reset_q", q_w[1], 32'h0);
    check("reset_pend", {31'b0, pend_w[1]}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 5'd7, 32'h100 + 32'(i));
      pat[4-i] = st_obs;
    end
    check("d3_stall_pattern", {27'b0, pat}, {27'b0, 5'b11101});
    check("d3_q_last", q_w[1], 32'h104);

    // DELAY=3, dst=0 never stalls
    cyc(1, 0, 1, 5'd0, 32'h0);
    cyc(0, 1, 1, 5'd0, 32'hA5A5_0001);
    check("nodst_stalled", {31'b0, st_obs}, 32'h0);
    check("nodst_q", q_w[1], 32'hA5A5_0001);

    // DELAY=4, withdrawal in cycle 2 then fresh request
    select(2, 4);
    cyc(1, 0, 1, 5'd0, 32'h0);
    cyc(0, 1, 1, 5'd3, 32'h1);
    cyc(0, 1, 1, 5'd3, 32'h2);
    cyc(0, 0, 1, 5'd3, 32'h3);
    check("d4_withdraw", {31'b0, st_obs}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 5'd3, 32'h10 + 32'(i));
      pat[4-i] = st_obs;
    end
    check("d4_restall_pattern", {27'b0, pat}, {27'b0, 5'b11110});

    // squash queueing
    select(1, 3);
    cyc(1, 0, 1, 5'd0, 32'h0);
    cyc(0, 1, 1, 5'd0, 32'h1234);
    cyc(0, 0, 0, 5'd0, 32'hDEAD);
    check("sq_pend_set", {31'b0, pend_w[1]}, 32'h1);
    check("sq_q_hold", q_w[1], 32'h1234);
    cyc(0, 0, 1, 5'd0, 32'hBEEF);
    cyc(0, 1, 1, 5'd0, 32'hFFFF);
    check("sq_apply_q", q_w[1], 32'h0);
    check("sq_apply_pend", {31'b0, pend_w[1]}, 32'h0);
    cyc(0, 1, 1, 5'd0, 32'hFFFF);
    check("sq_reload", q_w[1], 32'hFFFF);
    cyc(0, 0, 0, 5'd0, 32'h0);
    cyc(0, 1, 0, 5'd0, 32'h5555);
    check("sq_double_q", q_w[1], 32'h0);
    cyc(0, 1, 1, 5'd0, 32'h7777);
    check("sq_single_clear", q_w[1], 32'h7777);

    // DELAY=5, reset mid-stall
    select(3, 5);
    cyc(1, 0, 1, 5'd0, 32'h0);
    cyc(0, 1, 1, 5'd9, 32'hA);
    cyc(0, 1, 0, 5'd9, 32'hB);
    cyc(1, 1, 1, 5'd9, 32'hC);
    check("rst_stalled", {31'b0, st_obs}, 32'h0);
    check("rst_q", q_w[3], 32'h0);
    check("rst_pend", {31'b0, pend_w[3]}, 32'h0);
    nst = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1, 5'd9, 32'h20 + 32'(i));
      if (i < 5) nst += int'(st_obs);
    end
    check("rst_full_stall", 32'(nst), 32'd5);
    check("rst_release", {31'b0, st_obs}, 32'h0);

    // DELAY=0, random traffic against the reference pipereg model
    select(0, 0);
    cyc(1, 0, 1, 5'd0, 32'h0);
    nst = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 3)), $urandom);
      nst += int'(st_obs);
    end
    check("d0_never_stalled", 32'(nst), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
